bus_matrix_arbiter: RTL and testbench
=====================================

# bus_matrix_arbiter

Parametrised successor to the fixed two-master/three-slave serial bus arbiter. It arbitrates NUM_M bit-serial masters onto NUM_S bit-serial slaves. It decodes the target slave from the leading address bits and routes one master to one slave until the transaction ends. It sits between the master and slave instances in the system top level, and a single instance replaces the dedicated arbiter.

## Interface
- NUM_M, 2: number of masters, 2..8
- NUM_S, 3: number of slaves, 2..8
- SEL_W, 2: slave-select bits at the head of each address; requires 2^SEL_W ≥ NUM_S
- clk  in  1  system clock; every register updates on the rising edge
- reset  in  1  synchronous, active-high
- m_request  in  NUM_M  per-master bus request
- m_address, m_address_valid  in  NUM_M each  serial address bit and its qualifier
- m_data, m_valid, m_write_en, m_burst  in  NUM_M each  serial write data, data qualifier, write enable, burst flag
- m_available  out  NUM_M  one-hot grant
- m_ready, m_data_out, m_valid_in  out  NUM_M each  slave ready, read bit and read qualifier, routed to the granted master only
- m_error  out  NUM_M  one-cycle decode-error pulse to the granted master
- s_address, s_data, s_valid, s_write_en, s_burst, bus_ready_s  out  NUM_S each  routed to the selected slave only
- s_ready, s_data_in, s_valid_out, s_hold  in  NUM_S each  slave responses
- state  out  3  current FSM state
- owner  out  3  index of the granted master; 0 when the bus is idle

## Operation
- FSM states: IDLE=0, GRANT=1, SELECT=2, CONNECT=3, ERROR=4.
- IDLE:
  - If any m_request bit is high, choose a winner, register owner and a one-hot m_available, then go to GRANT.
  - With no request, stay in IDLE.
- GRANT: wait for m_address_valid[owner]. On its first high cycle, capture that bit as select bit MSB and go to SELECT.
- SELECT:
  - Shift in the remaining SEL_W−1 bits, MSB first, one per cycle when m_address_valid[owner] is high. Cycles with the qualifier low are ignored.
  - After the last bit: if the select value is below NUM_S, register sel and go to CONNECT. Otherwise go to ERROR.
  - Select bits are consumed by the arbiter and never forwarded to a slave.
- CONNECT:
  - Combinational routing: owner's address, data, valid, write_en and burst go to slave sel. bus_ready_s[sel] is 1.
  - Slave sel's ready, data_in and valid_out go back to the owner.
  - Every non-selected output is held at 0.
  - Address bits arriving after the select field pass through unchanged.
- Release: when m_request[owner]=0 and s_hold[sel]=0, go to IDLE. m_available clears and all routing drops at that edge.
  - If s_hold[sel]=1, the connection persists regardless of the request.
- ERROR: pulse m_error[owner] for one cycle, clear m_available, go to IDLE.
- A master dropping m_request during GRANT or SELECT aborts the transaction: return to IDLE, nothing is forwarded.
- Winner selection:
  - Fixed priority: the lowest-index requester wins.
  - Round robin: build option, see Configuration.
- Non-owner requests are ignored until the FSM returns to IDLE.

## Timing
- Reset values: state=IDLE, owner=0, sel=0, all m_* and s_* outputs 0, round-robin pointer=0.
- Reset asserted mid-transaction returns the block to IDLE at the next edge and drops every grant.
- Request to grant: m_available rises on the edge after the first cycle m_request is seen in IDLE (1-cycle latency).
- Select phase: SEL_W qualified address cycles.
- Routing latency: CONNECT begins on the edge after the last select bit. Routing in CONNECT is combinational, with no added latency between master and slave.
- A request arriving in the same cycle as a release is granted no earlier than the edge after the IDLE cycle.
- Simultaneous requests in IDLE are resolved entirely by the arbitration rule; exactly one m_available bit is ever high.

## Configuration
- ARB_ROUND_ROBIN_EN defined:
  - The winner is the first requester at or after the pointer, searching with wrap-around.
  - On every grant the pointer is set to winner+1 mod NUM_M.
- ARB_ROUND_ROBIN_EN undefined: fixed priority with master 0 highest, and no pointer register is implemented.

## Test plan
- NUM_M=2, NUM_S=3, SEL_W=2. Master 0 requests and sends select 2'b01 plus 12 address bits, then a write -> m_available=2'b01 one cycle after the request, slave 1 sees exactly the 12 address bits, other slaves' outputs stay 0.
- Both masters request in the same cycle, fixed priority -> master 0 is granted. With ARB_ROUND_ROBIN_EN, back-to-back contention grants 0, 1, 0, 1.
- Select 2'b11 with NUM_S=3 -> one-cycle m_error[owner] pulse, state ERROR then IDLE, no slave output toggles.
- Slave holds s_hold=1 after the master drops its request -> the connection stays up until hold falls, then IDLE on the next edge.
- Read from slave 2 -> s_data_in[2] and s_valid_out[2] appear on m_data_out[owner] and m_valid_in[owner] in the same cycle; the non-owner's read outputs stay 0.
- Reset pulsed during CONNECT -> all outputs 0, state=0 and owner=0 after one edge. A subsequent request is granted normally.

Source files
------------

// File: rtl/bus_matrix_arbiter.sv
// bus_matrix_arbiter: connects one of NUM_M bit-serial masters to one of
// NUM_S bit-serial slaves. The leading SEL_W address bits pick the slave and
// are consumed here; later address bits and all data pass straight through.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin arbitration;
// the default build uses fixed priority (master 0 highest).
module bus_matrix_arbiter #(
    parameter int NUM_M = 2,
    parameter int NUM_S = 3,
    parameter int SEL_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NUM_M-1:0] m_request,
    input  logic [NUM_M-1:0] m_address,
    input  logic [NUM_M-1:0] m_address_valid,
    input  logic [NUM_M-1:0] m_data,
    input  logic [NUM_M-1:0] m_valid,
    input  logic [NUM_M-1:0] m_write_en,
    input  logic [NUM_M-1:0] m_burst,
    output logic [NUM_M-1:0] m_available,
    output logic [NUM_M-1:0] m_ready,
    output logic [NUM_M-1:0] m_data_out,
    output logic [NUM_M-1:0] m_valid_in,
    output logic [NUM_M-1:0] m_error,
    output logic [NUM_S-1:0] s_address,
    output logic [NUM_S-1:0] s_data,
    output logic [NUM_S-1:0] s_valid,
    output logic [NUM_S-1:0] s_write_en,
    output logic [NUM_S-1:0] s_burst,
    output logic [NUM_S-1:0] bus_ready_s,
    input  logic [NUM_S-1:0] s_ready,
    input  logic [NUM_S-1:0] s_data_in,
    input  logic [NUM_S-1:0] s_valid_out,
    input  logic [NUM_S-1:0] s_hold,
    output logic [2:0]       state,
    output logic [2:0]       owner
);

    localparam int OW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam int SW = (NUM_S > 1) ? $clog2(NUM_S) : 1;
    localparam int CW = $clog2(SEL_W + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GRANT   = 3'd1,
        SELECT  = 3'd2,
        CONNECT = 3'd3,
        ERROR   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [OW-1:0]    owner_q, owner_d;
    logic [SW-1:0]    sel_q, sel_d;
    logic [SEL_W-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [OW-1:0]    winner;
    logic             any_req;
    logic [SEL_W-1:0] cand;
    logic [SEL_W-1:0] sel_val;
    logic             sel_done;
    logic [NUM_M-1:0] owner_oh;
`ifdef ARB_ROUND_ROBIN_EN
    logic [OW-1:0]    ptr_q, ptr_d;
    logic [OW-1:0]    rr_idx;
    logic             rr_found;
    int               rr_sum;
`endif

    // Winner of the current request vector (only consumed in IDLE).
    always_comb begin
        winner  = '0;
        any_req = |m_request;
`ifdef ARB_ROUND_ROBIN_EN
        rr_idx   = '0;
        rr_found = 1'b0;
        rr_sum   = 0;
        // First requester at or after the pointer, wrapping past NUM_M-1.
        for (int k = 0; k < NUM_M; k++) begin
            rr_sum = int'(ptr_q) + k;
            if (rr_sum >= NUM_M) rr_sum = rr_sum - NUM_M;
            rr_idx = OW'(rr_sum);
            if (!rr_found && m_request[rr_idx]) begin
                winner   = rr_idx;
                rr_found = 1'b1;
            end
        end
`else
        // Descending scan so the lowest requesting index is written last.
        for (int i = NUM_M - 1; i >= 0; i--) begin
            if (m_request[OW'(i)]) winner = OW'(i);
        end
`endif
    end

    // Next-state logic: grant, select-field capture, connection and release.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        sel_d    = sel_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        sel_done = 1'b0;
        sel_val  = shift_q;
        cand     = (shift_q << 1) | SEL_W'(m_address[owner_q]);
`ifdef ARB_ROUND_ROBIN_EN
        ptr_d    = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    owner_d = winner;
                    shift_d = '0;
                    cnt_d   = '0;
                    state_d = GRANT;
`ifdef ARB_ROUND_ROBIN_EN
                    ptr_d   = (winner == OW'(NUM_M - 1)) ? '0 : winner + OW'(1);
`endif
                end
            end
            GRANT: begin
                if (!m_request[owner_q]) begin
                    owner_d = '0;
                    state_d = IDLE;
                end else if (m_address_valid[owner_q]) begin
                    shift_d = SEL_W'(m_address[owner_q]);
                    cnt_d   = CW'(1);
                    state_d = SELECT;
                end
            end
            SELECT: begin
                if (!m_request[owner_q]) begin
                    owner_d = '0;
                    state_d = IDLE;
                end else if (cnt_q == CW'(SEL_W)) begin
                    // Only reachable with a one-bit select field.
                    sel_done = 1'b1;
                    sel_val  = shift_q;
                end else if (m_address_valid[owner_q]) begin
                    shift_d = cand;
                    cnt_d   = cnt_q + CW'(1);
                    if (cnt_q == CW'(SEL_W - 1)) begin
                        sel_done = 1'b1;
                        sel_val  = cand;
                    end
                end
                if (sel_done) begin
                    if (int'(sel_val) < NUM_S) begin
                        sel_d   = SW'(sel_val);
                        state_d = CONNECT;
                    end else begin
                        state_d = ERROR;
                    end
                end
            end
            CONNECT: begin
                // A holding slave keeps the path up even after the request drops.
                if (!m_request[owner_q] && !s_hold[sel_q]) begin
                    owner_d = '0;
                    sel_d   = '0;
                    state_d = IDLE;
                end
            end
            ERROR: begin
                owner_d = '0;
                state_d = IDLE;
            end
            default: begin
                owner_d = '0;
                sel_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State and arbitration registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= '0;
            sel_q   <= '0;
            shift_q <= '0;
            cnt_q   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            ptr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            sel_q   <= sel_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
`ifdef ARB_ROUND_ROBIN_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    // Grant/error decode and combinational master<->slave routing.
    always_comb begin
        owner_oh          = '0;
        owner_oh[owner_q] = 1'b1;
        m_available = '0;
        m_error     = '0;
        m_ready     = '0;
        m_data_out  = '0;
        m_valid_in  = '0;
        s_address   = '0;
        s_data      = '0;
        s_valid     = '0;
        s_write_en  = '0;
        s_burst     = '0;
        bus_ready_s = '0;
        if (state_q == GRANT || state_q == SELECT || state_q == CONNECT) begin
            m_available = owner_oh;
        end
        if (state_q == ERROR) begin
            m_error = owner_oh;
        end
        if (state_q == CONNECT) begin
            s_address[sel_q]   = m_address[owner_q];
            s_data[sel_q]      = m_data[owner_q];
            s_valid[sel_q]     = m_valid[owner_q];
            s_write_en[sel_q]  = m_write_en[owner_q];
            s_burst[sel_q]     = m_burst[owner_q];
            bus_ready_s[sel_q] = 1'b1;
            m_ready[owner_q]    = s_ready[sel_q];
            m_data_out[owner_q] = s_data_in[sel_q];
            m_valid_in[owner_q] = s_valid_out[sel_q];
        end
    end

    assign state = state_q;
    assign owner = 3'(owner_q);

endmodule

// File: tb/tb_bus_matrix_arbiter.sv
// Directed bench for bus_matrix_arbiter with NUM_M=2, NUM_S=3, SEL_W=2.
// Expected round-robin order is used when ARB_ROUND_ROBIN_EN is defined.
module tb_bus_matrix_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] m_request, m_address, m_address_valid;
    logic [1:0] m_data, m_valid, m_write_en, m_burst;
    logic [1:0] m_available, m_ready, m_data_out, m_valid_in, m_error;
    logic [2:0] s_address, s_data, s_valid, s_write_en, s_burst, bus_ready_s;
    logic [2:0] s_ready, s_data_in, s_valid_out, s_hold;
    logic [2:0] state, owner;
    logic [2:0] s_or;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign s_or = s_address | s_data | s_valid | s_write_en | s_burst | bus_ready_s;

    bus_matrix_arbiter #(.NUM_M(2), .NUM_S(3), .SEL_W(2)) dut (
        .clk(clk), .reset(reset),
        .m_request(m_request), .m_address(m_address), .m_address_valid(m_address_valid),
        .m_data(m_data), .m_valid(m_valid), .m_write_en(m_write_en), .m_burst(m_burst),
        .m_available(m_available), .m_ready(m_ready), .m_data_out(m_data_out),
        .m_valid_in(m_valid_in), .m_error(m_error),
        .s_address(s_address), .s_data(s_data), .s_valid(s_valid),
        .s_write_en(s_write_en), .s_burst(s_burst), .bus_ready_s(bus_ready_s),
        .s_ready(s_ready), .s_data_in(s_data_in), .s_valid_out(s_valid_out), .s_hold(s_hold),
        .state(state), .owner(owner)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m_request = '0; m_address = '0; m_address_valid = '0;
        m_data = '0; m_valid = '0; m_write_en = '0; m_burst = '0;
        s_ready = '0; s_data_in = '0; s_valid_out = '0; s_hold = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    // Drives the request and the two select bits; ends in CONNECT.
    task automatic connect(input logic [1:0] moh, input logic [1:0] sel);
        m_request = m_request | moh;
        cyc();
        m_address_valid = moh;
        m_address = sel[1] ? moh : 2'b00;
        cyc();
        m_address = sel[0] ? moh : 2'b00;
        cyc();
        m_address_valid = '0;
        m_address = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        m_request = 2'b11;
        reset = 1'b1;
        cyc();
        cyc();
        checks++;
        if (state !== 3'd0 || owner !== 3'd0) begin
            errors++; $display("FAIL reset_state: state=%0d owner=%0d want 0 0", state, owner);
        end
        checks++;
        if (m_available !== 2'b00 || m_error !== 2'b00 || s_or !== 3'b000) begin
            errors++; $display("FAIL reset_outputs: avail=%b err=%b s=%b want 0", m_available, m_error, s_or);
        end
        m_request = '0;
        reset = 1'b0;
        cyc();
    endtask

    task automatic test_write();
        logic [11:0] pat;
        logic [11:0] got;
        logic        other;
        pat = 12'hA5C;
        got = '0;
        other = 1'b0;
        m_request = 2'b01;
        #1;
        checks++;
        if (m_available !== 2'b00) begin
            errors++; $display("FAIL grant_early: avail=%b want 00", m_available);
        end
        cyc();
        checks++;
        if (m_available !== 2'b01 || state !== 3'd1 || owner !== 3'd0) begin
            errors++; $display("FAIL grant_m0: avail=%b state=%0d owner=%0d want 01 1 0", m_available, state, owner);
        end
        m_address_valid = 2'b01; m_address = 2'b00;
        cyc();
        m_address_valid = 2'b00;
        #1;
        checks++;
        if (state !== 3'd2 || s_or !== 3'b000) begin
            errors++; $display("FAIL select_enter: state=%0d s=%b want 2 000", state, s_or);
        end
        cyc();
        m_address_valid = 2'b01; m_address = 2'b01;
        #1;
        checks++;
        if (state !== 3'd2 || s_or !== 3'b000) begin
            errors++; $display("FAIL select_stall: state=%0d s=%b want 2 000", state, s_or);
        end
        cyc();
        checks++;
        if (state !== 3'd3 || bus_ready_s !== 3'b010) begin
            errors++; $display("FAIL connect_s1: state=%0d bus_ready=%b want 3 010", state, bus_ready_s);
        end
        for (int i = 11; i >= 0; i--) begin
            m_address[0] = pat[i];
            m_address_valid[0] = 1'b1;
            #1;
            got[i] = s_address[1];
            other = other | s_address[0] | s_address[2];
            cyc();
        end
        checks++;
        if (got !== pat) begin
            errors++; $display("FAIL addr_stream: got %h want %h", got, pat);
        end
        checks++;
        if (other !== 1'b0) begin
            errors++; $display("FAIL addr_leak: got %b want 0", other);
        end
        m_address = '0; m_address_valid = '0;
        m_valid = 2'b01; m_write_en = 2'b01; m_data = 2'b01; m_burst = 2'b01;
        #1;
        checks++;
        if (s_valid !== 3'b010 || s_write_en !== 3'b010 || s_data !== 3'b010 || s_burst !== 3'b010) begin
            errors++; $display("FAIL write_route: v=%b we=%b d=%b b=%b want 010", s_valid, s_write_en, s_data, s_burst);
        end
        cyc();
        m_data = 2'b00;
        #1;
        checks++;
        if (s_data !== 3'b000 || s_valid !== 3'b010) begin
            errors++; $display("FAIL write_data0: d=%b v=%b want 000 010", s_data, s_valid);
        end
        clear_inputs();
        cyc();
        checks++;
        if (state !== 3'd0 || m_available !== 2'b00 || owner !== 3'd0 || s_or !== 3'b000) begin
            errors++; $display("FAIL release: state=%0d avail=%b owner=%0d s=%b want 0 00 0 000", state, m_available, owner, s_or);
        end
    endtask

    task automatic test_priority();
        do_reset();
        m_request = 2'b11;
        cyc();
        checks++;
        if (m_available !== 2'b01 || owner !== 3'd0) begin
            errors++; $display("FAIL priority: avail=%b owner=%0d want 01 0", m_available, owner);
        end
        m_request = 2'b00;
        cyc();
        checks++;
        if (state !== 3'd0 || m_available !== 2'b00) begin
            errors++; $display("FAIL abort_grant: state=%0d avail=%b want 0 00", state, m_available);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp;
        do_reset();
        for (int r = 0; r < 4; r++) begin
`ifdef ARB_ROUND_ROBIN_EN
            exp = (r % 2 == 0) ? 2'b01 : 2'b10;
`else
            exp = 2'b01;
`endif
            m_request = 2'b11;
            cyc();
            checks++;
            if (m_available !== exp || state !== 3'd1) begin
                errors++; $display("FAIL b2b_grant%0d: avail=%b state=%0d want %b 1", r, m_available, state, exp);
            end
            cyc();
            checks++;
            if (m_available !== exp) begin
                errors++; $display("FAIL b2b_hold%0d: avail=%b want %b", r, m_available, exp);
            end
            m_request = 2'b00;
            cyc();
            checks++;
            if (state !== 3'd0) begin
                errors++; $display("FAIL b2b_idle%0d: state=%0d want 0", r, state);
            end
        end
    endtask

    task automatic test_error();
        clear_inputs();
        m_request = 2'b10;
        cyc();
        checks++;
        if (m_available !== 2'b10 || owner !== 3'd1) begin
            errors++; $display("FAIL grant_m1: avail=%b owner=%0d want 10 1", m_available, owner);
        end
        m_address_valid = 2'b10; m_address = 2'b10;
        cyc();
        checks++;
        if (state !== 3'd2 || s_or !== 3'b000) begin
            errors++; $display("FAIL err_select: state=%0d s=%b want 2 000", state, s_or);
        end
        cyc();
        checks++;
        if (state !== 3'd4 || m_error !== 2'b10 || m_available !== 2'b00 || s_or !== 3'b000) begin
            errors++; $display("FAIL err_pulse: state=%0d err=%b avail=%b s=%b want 4 10 00 000", state, m_error, m_available, s_or);
        end
        clear_inputs();
        cyc();
        checks++;
        if (state !== 3'd0 || m_error !== 2'b00 || owner !== 3'd0 || s_or !== 3'b000) begin
            errors++; $display("FAIL err_end: state=%0d err=%b owner=%0d s=%b want 0 00 0 000", state, m_error, owner, s_or);
        end
    endtask

    task automatic test_hold();
        clear_inputs();
        connect(2'b01, 2'b00);
        checks++;
        if (state !== 3'd3 || bus_ready_s !== 3'b001) begin
            errors++; $display("FAIL hold_connect: state=%0d bus_ready=%b want 3 001", state, bus_ready_s);
        end
        s_hold = 3'b001;
        m_request = 2'b00;
        cyc();
        cyc();
        checks++;
        if (state !== 3'd3 || m_available !== 2'b01 || bus_ready_s !== 3'b001) begin
            errors++; $display("FAIL hold_keep: state=%0d avail=%b bus_ready=%b want 3 01 001", state, m_available, bus_ready_s);
        end
        s_hold = 3'b000;
        #1;
        checks++;
        if (state !== 3'd3) begin
            errors++; $display("FAIL hold_drop_same: state=%0d want 3", state);
        end
        cyc();
        checks++;
        if (state !== 3'd0 || m_available !== 2'b00 || bus_ready_s !== 3'b000) begin
            errors++; $display("FAIL hold_release: state=%0d avail=%b bus_ready=%b want 0 00 000", state, m_available, bus_ready_s);
        end
    endtask

    task automatic test_read();
        clear_inputs();
        connect(2'b10, 2'b10);
        checks++;
        if (state !== 3'd3 || owner !== 3'd1 || bus_ready_s !== 3'b100) begin
            errors++; $display("FAIL read_connect: state=%0d owner=%0d bus_ready=%b want 3 1 100", state, owner, bus_ready_s);
        end
        s_ready = 3'b100; s_data_in = 3'b101; s_valid_out = 3'b100;
        #1;
        checks++;
        if (m_ready !== 2'b10 || m_data_out !== 2'b10 || m_valid_in !== 2'b10) begin
            errors++; $display("FAIL read_route: rdy=%b d=%b v=%b want 10 10 10", m_ready, m_data_out, m_valid_in);
        end
        s_data_in = 3'b001; s_valid_out = 3'b011; s_ready = 3'b011;
        #1;
        checks++;
        if (m_ready !== 2'b00 || m_data_out !== 2'b00 || m_valid_in !== 2'b00) begin
            errors++; $display("FAIL read_isolate: rdy=%b d=%b v=%b want 00 00 00", m_ready, m_data_out, m_valid_in);
        end
        clear_inputs();
        cyc();
        checks++;
        if (state !== 3'd0) begin
            errors++; $display("FAIL read_release: state=%0d want 0", state);
        end
    endtask

    task automatic test_reset_mid();
        clear_inputs();
        connect(2'b01, 2'b01);
        m_valid = 2'b01;
        #1;
        checks++;
        if (s_valid !== 3'b010) begin
            errors++; $display("FAIL mid_route: v=%b want 010", s_valid);
        end
        reset = 1'b1;
        cyc();
        checks++;
        if (state !== 3'd0 || owner !== 3'd0 || m_available !== 2'b00 || s_or !== 3'b000) begin
            errors++; $display("FAIL mid_reset: state=%0d owner=%0d avail=%b s=%b want 0 0 00 000", state, owner, m_available, s_or);
        end
        reset = 1'b0;
        m_valid = 2'b00;
        cyc();
        checks++;
        if (m_available !== 2'b01 || state !== 3'd1) begin
            errors++; $display("FAIL post_reset_grant: avail=%b state=%0d want 01 1", m_available, state);
        end
        m_request = 2'b00;
        cyc();
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        test_reset();
        test_write();
        test_priority();
        test_back_to_back();
        test_error();
        test_hold();
        test_read();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
